// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM encoding and GF(2^8)
// helpers for the iterative AES-128 encrypt datapath.
package aes_pkg;

   localparam int NR    = 10;
   localparam int BLK_W = 128;
   localparam int RK_W  = (NR + 1) * BLK_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ROUND = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // one state column, row 0 in the top byte
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0;
      b2 = xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1;
      b3 = xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2;
      return {b0, b1, b2, b3};
   endfunction

   // byte i sits at row i%4, column i/4; row r rotates left by r
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES round.
// last=1 skips MixColumns for the final round.
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [BLK_W-1:0] st,
   input  logic [BLK_W-1:0] rk,
   input  logic             last,
   output logic [BLK_W-1:0] next_st
);

   logic [BLK_W-1:0] sb;
   logic [BLK_W-1:0] sr;
   logic [BLK_W-1:0] mc;

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      sbox u_sbox (
         .a (st[8*i +: 8]),
         .y (sb[8*i +: 8])
      );
   end

   assign sr = shift_rows(sb);

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
   end

   assign next_st = (last ? sr : mc) ^ rk;

endmodule

// File: rtl/sbox.sv
// sbox: AES forward substitution box,
// one byte in, one byte out, purely combinational.
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [7:0] TBL [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = TBL[a];

endmodule

// File: rtl/aes_encrypt_iter_128.sv
// aes_encrypt_iter_128: iterative AES-128 encrypt, one round per clock.
// Option: AES_KEY_LATCH_EN captures round_keys at accept.
module aes_encrypt_iter_128 #(
   parameter int NR    = aes_pkg::NR,
   parameter int BLK_W = aes_pkg::BLK_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BLK_W-1:0]        pt,
   input  logic [(NR+1)*BLK_W-1:0] round_keys,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BLK_W-1:0]        ct,
   output logic                    busy
);
   import aes_pkg::RK_W, aes_pkg::IDLE, aes_pkg::ROUND, aes_pkg::DONE;

   if (NR != 10 || BLK_W != 128) begin : g_bad_cfg
      $error("aes_encrypt_iter_128: only NR=10, BLK_W=128");
   end

   logic [1:0]       state;
   logic [3:0]       rnd;
   logic [BLK_W-1:0] st;
   logic [BLK_W-1:0] next_st;
   logic [RK_W-1:0]  key_src;
   logic [BLK_W-1:0] ks [NR+1];
   logic             accept;
   logic             last;
   logic [BLK_W-1:0] init_st;

   assign in_ready  = (state == IDLE) ||
                      (state == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state == ROUND);
   assign ct        = st;
   assign last      = (rnd == 4'(NR));
   assign init_st   = pt ^ round_keys[RK_W-1 -: BLK_W];

`ifdef AES_KEY_LATCH_EN
   logic [RK_W-1:0] key_q;

   // hold the block's key schedule so upstream may move on
   always_ff @(posedge clk) begin
      if (rst)
         key_q <= '0;
      else if (accept)
         key_q <= round_keys;
   end

   assign key_src = key_q;
`else
   assign key_src = round_keys;
`endif

   // split the flattened schedule; key_s0 is the top slice
   always_comb begin
      for (int i = 0; i <= NR; i++)
         ks[i] = key_src[RK_W-1-BLK_W*i -: BLK_W];
   end

   aes_round_comb u_round (
      .st      (st),
      .rk      (ks[rnd]),
      .last    (last),
      .next_st (next_st)
   );

   // FSM, round counter and state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rnd   <= 4'd0;
         st    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  st    <= init_st;
                  rnd   <= 4'd1;
                  state <= ROUND;
               end
            end
            ROUND: begin
               if (rnd >= 4'd1 && rnd <= 4'(NR)) begin
                  st <= next_st;
                  if (last)
                     state <= DONE;
                  else
                     rnd <= rnd + 4'd1;
               end else begin
                  state <= IDLE;
               end
            end
            DONE: begin
               if (accept) begin
                  st    <= init_st;
                  rnd   <= 4'd1;
                  state <= ROUND;
               end else if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encrypt_iter_128.sv
// tb_aes_encrypt_iter_128: randomized and FIPS-197 vector bench
// against a byte-matrix AES reference model.
module tb_aes_encrypt_iter_128;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  pt;
   logic [1407:0] round_keys;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  ct;
   logic          busy;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] sb_m [256];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_encrypt_iter_128 dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pt         (pt),
      .round_keys (round_keys),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ct         (ct),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // GF(2^8) product: carry-less multiply then reduce mod x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int k = 14; k >= 8; k--)
         if (p[k]) p = p ^ (16'h11b << (k - 8));
      return p[7:0];
   endfunction

   // S-box from multiplicative inverse plus affine map
   task automatic build_sbox;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         sb_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                   {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] r;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
      return r;
   endfunction

   function automatic logic [127:0] model_enc(input logic [1407:0] rk,
                                              input logic [127:0] p);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] k;
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         s[i%4][i/4] = p[127-8*i -: 8] ^ rk[1407-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
               t[rr][c] = sb_m[s[rr][(c+rr)%4]];
         for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
               if (r == 10)
                  s[rr][c] = t[rr][c];
               else
                  s[rr][c] = gmul(8'h02, t[rr][c]) ^ gmul(8'h03, t[(rr+1)%4][c]) ^
                             t[(rr+2)%4][c] ^ t[(rr+3)%4][c];
         k = rk[1407-128*r -: 128];
         for (int i = 0; i < 16; i++)
            s[i%4][i/4] = s[i%4][i/4] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i%4][i/4];
      return o;
   endfunction

   task automatic run_block(input logic [127:0] key, input logic [127:0] p,
                            input logic [127:0] exp, input string name);
      int cyc;
      out_ready = 1'b0;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      else n_pass++;
      pt = p;
      round_keys = expand(key);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      n_total++;
      if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, busy);
      else n_pass++;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         tick;
         cyc++;
      end
      n_total++;
      if (cyc != 10) $display("FAIL %s latency: got %0d want 10", name, cyc);
      else n_pass++;
      n_total++;
      if (ct !== exp) $display("FAIL %s ct: got %h want %h", name, ct, exp);
      else n_pass++;
      out_ready = 1'b1;
      tick;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL %s release: got ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      pt = '0;
      round_keys = '0;
      tick;
      tick;
      rst = 1'b0;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy);
      else n_pass++;
      n_total++;
      if (ct !== 128'h0) $display("FAIL reset ct: got %h want 0", ct);
      else n_pass++;
   endtask

   task automatic test_fips;
      run_block(C1_KEY, C1_PT, C1_CT, "fips_c1");
      run_block(B_KEY, B_PT, B_CT, "fips_b");
   endtask

   task automatic test_random;
      for (int n = 0; n < 4; n++) begin
         logic [127:0] k, p;
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         run_block(k, p, model_enc(expand(k), p), "random");
      end
   endtask

   task automatic test_backpressure;
      int cyc;
      out_ready = 1'b0;
      pt = C1_PT;
      round_keys = expand(C1_KEY);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         tick;
         cyc++;
      end
      n_total++;
      if (cyc != 10) $display("FAIL bp latency: got %0d want 10", cyc);
      else n_pass++;
      in_valid = 1'b1;
      pt = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 20; i++) begin
         tick;
         n_total++;
         if (ct !== C1_CT || out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL bp hold %0d: got ct=%h ov=%b ir=%b want ct=%h ov=1 ir=0",
                     i, ct, out_valid, in_ready, C1_CT);
         else n_pass++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int cyc;
      out_ready = 1'b1;
      pt = C1_PT;
      round_keys = expand(C1_KEY);
      in_valid = 1'b1;
      tick;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         tick;
         cyc++;
      end
      n_total++;
      if (cyc != 10) $display("FAIL b2b first latency: got %0d want 10", cyc);
      else n_pass++;
      n_total++;
      if (ct !== C1_CT) $display("FAIL b2b first ct: got %h want %h", ct, C1_CT);
      else n_pass++;
      pt = B_PT;
      round_keys = expand(B_KEY);
      tick;
      in_valid = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b1)
         $display("FAIL b2b reload: got ov=%b busy=%b want ov=0 busy=1", out_valid, busy);
      else n_pass++;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 40) begin
         tick;
         cyc++;
      end
      n_total++;
      if (cyc != 11) $display("FAIL b2b spacing: got %0d want 11", cyc);
      else n_pass++;
      n_total++;
      if (ct !== B_CT) $display("FAIL b2b second ct: got %h want %h", ct, B_CT);
      else n_pass++;
      tick;
   endtask

   task automatic test_reset_mid;
      logic saw;
      out_ready = 1'b1;
      pt = C1_PT;
      round_keys = expand(C1_KEY);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (4) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL midrst state: got ov=%b busy=%b ir=%b want 0 0 1",
                  out_valid, busy, in_ready);
      else n_pass++;
      saw = 1'b0;
      repeat (15) begin
         tick;
         if (out_valid === 1'b1) saw = 1'b1;
      end
      n_total++;
      if (saw !== 1'b0) $display("FAIL midrst ghost output: got %b want 0", saw);
      else n_pass++;
      run_block(C1_KEY, C1_PT, C1_CT, "after_rst");
   endtask

`ifdef AES_KEY_LATCH_EN
   task automatic test_key_latch;
      int cyc;
      out_ready = 1'b1;
      pt = C1_PT;
      round_keys = expand(C1_KEY);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      round_keys = '1;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         tick;
         cyc++;
      end
      n_total++;
      if (ct !== C1_CT || out_valid !== 1'b1)
         $display("FAIL key_latch ct: got %h ov=%b want %h ov=1", ct, out_valid, C1_CT);
      else n_pass++;
      tick;
   endtask
`endif

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef AES_KEY_LATCH_EN
      test_key_latch();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_iter_128.md
Name: aes_encrypt_iter_128

Overview:
- Iterative AES-128 encryption datapath; one round per clock.
- Sits directly downstream of the combinational key-expansion block and consumes its eleven round keys as one flattened bus.
- Accepts one plaintext block per valid/ready handshake and returns ciphertext through a valid/ready output port.
- Reuses the existing sbox module: 16 instances for SubBytes.

Parameters:
- NR, 10: number of rounds. Only 10 is supported; any other value is an elaboration error.
- BLK_W, 128: block width. Fixed at 128.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  plaintext and round_keys are valid.
- in_ready  out  1  block can accept a new input this cycle.
- pt  in  128  plaintext, FIPS-197 byte order (byte 0 at [127:120]).
- round_keys  in  1408  {key_s0, key_s1, …, key_s10}; key_s0 occupies [1407:1280].
- out_valid  out  1  ct holds a finished ciphertext.
- out_ready  in  1  consumer accepts ct.
- ct  out  128  ciphertext.
- busy  out  1  high while in ROUND state.

Behaviour:
- State machine: IDLE, ROUND, DONE. 4-bit round counter rnd. 128-bit state register st.
- Reset (synchronous, rst high at an edge):
  - FSM goes to IDLE; rnd=0; st=0.
  - out_valid=0, in_ready=1 after the edge, busy=0, ct=0.
  - Reset mid-operation abandons the block; no output is produced for it.
- in_ready is combinational: (FSM==IDLE) || (FSM==DONE && out_ready).
- Accept: in_valid && in_ready at an edge.
  - st <= pt ^ key_s0; rnd <= 1; FSM -> ROUND.
- ROUND, rnd in 1..9: st <= MixColumns(ShiftRows(SubBytes(st))) ^ key_s[rnd]; rnd++.
- ROUND, rnd==10: st <= ShiftRows(SubBytes(st)) ^ key_s10, with no MixColumns; FSM -> DONE.
- Latency: out_valid rises exactly 10 cycles after the accept edge.
- DONE:
  - out_valid=1; ct=st.
  - Output is held stable until out_ready is high at an edge.
- Output handshake with no new input: FSM -> IDLE.
- Output handshake and input accept on the same edge: the new block is loaded (back-to-back), FSM -> ROUND, out_valid drops the next cycle. Peak throughput is one block per 11 cycles.
- in_valid while in ROUND is ignored; in_ready is low, so no data is lost.
- out_valid is never asserted while in ROUND.
- rnd beyond 10 cannot occur; the default branch returns to IDLE.
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
  - MixColumns uses 2·a ^ 3·b ^ c ^ d per byte.
- ShiftRows indexing is on the column-major FIPS state: byte i = row i%4, column i/4.

Optional Feature:
- Macro: AES_KEY_LATCH_EN.
- Defined:
  - A 1408-bit key register captures round_keys on the accept edge; rounds use the captured copy.
  - round_keys may change freely after acceptance.
  - The register resets to 0.
- Undefined:
  - Rounds read round_keys live.
  - The upstream side must hold round_keys stable from accept until out_valid&&out_ready.
  - Changing round_keys during ROUND produces undefined ct; the bench must not do this in this configuration.

Decomposition:
- Shared package aes_pkg holds:
  - constants NR=10, BLK_W=128, RK_W=1408;
  - FSM state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2);
  - functions xtime, mix_column (32-bit) and shift_rows (128-bit).
- One sub-module, aes_round_comb: combinational round with input st, input rk, input last, output next_st; it instantiates the 16 sbox modules.
- The top-level block holds the FSM, counter, registers and handshake only.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Response: ct 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Response: ct 3925841d02dc09fbdc118597196a0b32.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Response: ct stable, out_valid held, in_ready=0. Raise out_ready: out_valid falls the next cycle, in_ready=1.
- Back-to-back:
  - Stimulus: in_valid held high with out_ready=1, two C.1/B vectors.
  - Response: both ciphertexts correct; second out_valid 11 cycles after the first.
- Reset mid-run:
  - Stimulus: assert rst at rnd=5.
  - Response: out_valid=0, busy=0, in_ready=1 after the edge. A following C.1 run still yields 69c4e0d8….
- With AES_KEY_LATCH_EN defined:
  - Stimulus: change round_keys to all-ones one cycle after accepting C.1.
  - Response: ct still 69c4e0d86a7b0430d8cdb78070b4c55a.
